instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage between rom and decoderWithCc. Captures the ROM nibble stream at M1 and M2
//  and assembles complete instructions, including the 4004 two-word forms.
//  Presents stable opr/opa, a second-word byte and a jump address for the X1..X3 phase of
//  each instruction's final word. Flags the FIN data cycle so cpuTop can hold the PC and
//  remux the ROM address.
// PARAMETERS
//  CYCLE_M1  3  cycle index at which romNibble carries OPR / high nibble of word 2
//  CYCLE_M2  4  cycle index at which romNibble carries OPA / low nibble of word 2
//  CYCLE_X3  7  last cycle of the instruction cycle; instrValid is cleared after it
// PORTS
//  clk         in   1   toggle clock, same as clockReset/pc
//  rstN        in   1   asynchronous, active-low reset
//  cycle       in   3   0..7 cycle index from clockReset
//  romNibble   in   4   rom.nibble
//  opr         out  4   OPR of the assembled instruction (word 1)
//  opa         out  4   OPA of the assembled instruction (word 1)
//  operand2    out  8   second word {M1,M2}, or FIN data byte; 0 for one-word instructions
//  jumpAddr    out  12  {opa, operand2}; meaningful for JUN/JMS only
//  twoWord     out  1   current opr/opa came with a second word/cycle
//  instrValid  out  1   high during cycles 5..7 of the instruction's final word
//  secondFetch out  1   high for the whole instruction cycle fetching word 2 (PC still increments)
//  finFetch    out  1   high for the whole FIN data cycle (PC holds, address = register pair)
// BEHAVIOUR
//  - Reset (async, rstN=0): state=FETCH1. opr=opa=0 (NOP). operand2=0. twoWord=0.
//    instrValid=0. secondFetch=finFetch=0. m1Hold=0. Reset mid-instruction discards all partial words.
//  - States: FETCH1 (word 1), FETCH2 (word 2 of JCN/FIM/JUN/JMS/ISZ), FINDATA (FIN byte).
//  - Edge with cycle==CYCLE_M1: m1Hold<=romNibble (every state).
//  - Edge with cycle==CYCLE_M2 in FETCH1: classify {m1Hold,romNibble}:
//      two-word when OPR=1 (JCN), OPR=2 & OPA[0]=0 (FIM), OPR=4 (JUN), OPR=5 (JMS), OPR=7 (ISZ)
//        -> w1<= {m1Hold,romNibble}; state<=FETCH2. opr/opa/instrValid are not updated.
//      FIN when OPR=3 & OPA[0]=0 -> w1 latched; state<=FINDATA.
//      otherwise -> opr<=m1Hold; opa<=romNibble; operand2<=0; twoWord<=0; instrValid<=1.
//  - Edge with cycle==CYCLE_M2 in FETCH2 or FINDATA: opr/opa<=w1; operand2<={m1Hold,romNibble};
//    twoWord<=1; instrValid<=1; state<=FETCH1.
//  - Edge with cycle==CYCLE_X3: instrValid<=0. Valid window = cycles 5,6,7 only, one per instruction.
//  - secondFetch/finFetch are registered from the next state on the CYCLE_X3 edge.
//    They are therefore high from cycle 0 to cycle 7 of the extra instruction cycle.
//  - opr/opa/operand2/twoWord hold until the next commit; the decoder may sample any time in 5..7.
//  - The opcode fields of word 2 are never reinterpreted (e.g. JUN 0x4,0x0 / 0x40 is not re-decoded as JUN).
//  - FIN whose data byte is itself a two-word opcode: the byte is treated as data only.
//  - Cycle skips/glitches: captures fire only on exact index match; no recovery beyond rstN.
//  - PC wrap-around (0xFFF->0x000) between words is transparent; words are never address-checked.
//  - jumpAddr is combinational from registered opa/operand2; no other combinational outputs.
// STRUCTURE
//  - cpu4004Pkg (shared): CYCLE_* indices, OPR_JCN/FIM/FIN/JUN/JMS/ISZ codes,
//    fetchState_t {FETCH1,FETCH2,FINDATA}.
//  - One sub-module: instr_len_decode (comb: opr,opa -> isTwoWord,isFin). decoderWithCc reuses it.
//  - cpuTop: opr/opa feed decoderWithCc and alu.opa. finFetch gates pc increment.
// TESTING
//  1 ROM 0x00 (NOP) then 0xD5 (LDM 5): cycle 5 of 2nd instr -> opr=D opa=5 operand2=00
//    twoWord=0 instrValid=1 only in cycles 5..7.
//  2 JUN 0x4,0x3 then 0x21: no instrValid in the first cycle, secondFetch=1 in the second.
//    Cycle 5 of the second -> opr=4 opa=3 operand2=21 jumpAddr=0x321 twoWord=1.
//  3 FIM 0x2,0x4 + 0xAB -> two-word, operand2=AB. SRC 0x2,0x5 -> one-word, instrValid same cycle.
//  4 FIN 0x3,0x2, data nibbles A,B -> finFetch=1 for cycles 0..7 of the data cycle, secondFetch=0.
//    Then opr=3 opa=2 operand2=AB.
//  5 rstN pulsed low at cycle 2 of FETCH2 (after JMS word 1) -> outputs 0, state FETCH1.
//    The next 0xD7 decodes as LDM 7.
//  6 Back-to-back JCN 0x1,0x4 / 0x00 then ISZ 0x7,0x0 / 0xFF: two instrValid windows.
//    operand2=00 then FF. Never a spurious valid in word-2 cycles.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: cycle indices, two-word opcode codes and fetch state.
package instr_fetch_unit_pkg;

    localparam logic [2:0] DEF_CYCLE_M1 = 3'd3;
    localparam logic [2:0] DEF_CYCLE_M2 = 3'd4;
    localparam logic [2:0] DEF_CYCLE_X3 = 3'd7;

    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_FIN = 4'h3;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_ISZ = 4'h7;

    typedef enum logic [1:0] {
        FETCH1,
        FETCH2,
        FINDATA
    } fetch_state_e;

    typedef struct packed {
        logic [3:0] opr;
        logic [3:0] opa;
    } instr_word_t;

endpackage

// File: rtl/instr_len_decode.sv
// Instruction length classifier: flags 4004 opcodes that need a second ROM word or a FIN data cycle.
module instr_len_decode
    import instr_fetch_unit_pkg::*;
(
    input  logic [3:0] opr_i,
    input  logic [3:0] opa_i,
    output logic       is_two_word_o,
    output logic       is_fin_o
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        is_two_word_o = 1'b0;
        is_fin_o      = 1'b0;
        case (opr_i)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: is_two_word_o = 1'b1;
            OPR_FIM:                            is_two_word_o = ~opa_i[0];
            OPR_FIN:                            is_fin_o      = ~opa_i[0];
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: assembles one- and two-word 4004 instructions from the ROM nibble stream
// and presents them, stable, for the X1..X3 phase of the instruction's final word.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [2:0] CYCLE_M1 = DEF_CYCLE_M1,
    parameter logic [2:0] CYCLE_M2 = DEF_CYCLE_M2,
    parameter logic [2:0] CYCLE_X3 = DEF_CYCLE_X3
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [2:0]  cycle,
    input  logic [3:0]  romNibble,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic [7:0]  operand2,
    output logic [11:0] jumpAddr,
    output logic        twoWord,
    output logic        instrValid,
    output logic        secondFetch,
    output logic        finFetch
);

    fetch_state_e state_q, state_d;
    instr_word_t  w1_q, w1_d;
    logic [3:0]   m1_hold_q, m1_hold_d;

    logic [3:0]   opr_q, opr_d;
    logic [3:0]   opa_q, opa_d;
    logic [7:0]   operand2_q, operand2_d;
    logic         two_word_q, two_word_d;
    logic         instr_valid_q, instr_valid_d;
    logic         second_fetch_q, second_fetch_d;
    logic         fin_fetch_q, fin_fetch_d;

    logic         is_m1, is_m2, is_x3;
    logic         is_two_word, is_fin;

    assign is_m1 = (cycle == CYCLE_M1);
    assign is_m2 = (cycle == CYCLE_M2);
    assign is_x3 = (cycle == CYCLE_X3);

    // Word 1 is always formed from the held M1 nibble and the live M2 nibble.
    instr_len_decode u_len_decode (
        .opr_i         (m1_hold_q),
        .opa_i         (romNibble),
        .is_two_word_o (is_two_word),
        .is_fin_o      (is_fin)
    );

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= FETCH1;
            w1_q      <= '0;
            m1_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            w1_q      <= w1_d;
            m1_hold_q <= m1_hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w1_d      = w1_q;
        m1_hold_d = m1_hold_q;
        if (is_m1) begin
            m1_hold_d = romNibble;
        end
        if (is_m2) begin
            case (state_q)
                FETCH1: begin
                    if (is_two_word) begin
                        state_d = FETCH2;
                        w1_d    = '{opr: m1_hold_q, opa: romNibble};
                    end else if (is_fin) begin
                        state_d = FINDATA;
                        w1_d    = '{opr: m1_hold_q, opa: romNibble};
                    end
                end
                default: state_d = FETCH1;
            endcase
        end
    end

    // Word-2 and FIN data bytes are committed as operands only, never re-decoded.
    always_comb begin
        opr_d          = opr_q;
        opa_d          = opa_q;
        operand2_d     = operand2_q;
        two_word_d     = two_word_q;
        instr_valid_d  = instr_valid_q;
        second_fetch_d = second_fetch_q;
        fin_fetch_d    = fin_fetch_q;
        if (is_m2) begin
            if (state_q == FETCH1) begin
                if (!is_two_word && !is_fin) begin
                    opr_d         = m1_hold_q;
                    opa_d         = romNibble;
                    operand2_d    = '0;
                    two_word_d    = 1'b0;
                    instr_valid_d = 1'b1;
                end
            end else begin
                opr_d         = w1_q.opr;
                opa_d         = w1_q.opa;
                operand2_d    = {m1_hold_q, romNibble};
                two_word_d    = 1'b1;
                instr_valid_d = 1'b1;
            end
        end
        if (is_x3) begin
            instr_valid_d  = 1'b0;
            second_fetch_d = (state_d == FETCH2);
            fin_fetch_d    = (state_d == FINDATA);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            opr_q          <= '0;
            opa_q          <= '0;
            operand2_q     <= '0;
            two_word_q     <= 1'b0;
            instr_valid_q  <= 1'b0;
            second_fetch_q <= 1'b0;
            fin_fetch_q    <= 1'b0;
        end else begin
            opr_q          <= opr_d;
            opa_q          <= opa_d;
            operand2_q     <= operand2_d;
            two_word_q     <= two_word_d;
            instr_valid_q  <= instr_valid_d;
            second_fetch_q <= second_fetch_d;
            fin_fetch_q    <= fin_fetch_d;
        end
    end

    assign opr         = opr_q;
    assign opa         = opa_q;
    assign operand2    = operand2_q;
    assign jumpAddr    = {opa_q, operand2_q};
    assign twoWord     = two_word_q;
    assign instrValid  = instr_valid_q;
    assign secondFetch = second_fetch_q;
    assign finFetch    = fin_fetch_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: drives whole 8-cycle instruction cycles and checks
// the per-cycle valid/fetch flags plus the instruction presented at cycle 5.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  cycle;
    logic [3:0]  romNibble;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  operand2;
    logic [11:0] jumpAddr;
    logic        twoWord;
    logic        instrValid;
    logic        secondFetch;
    logic        finFetch;

    int checks = 0;
    int errors = 0;

    logic [7:0]  valid_bits, sf_bits, ff_bits;
    logic [3:0]  s_opr, s_opa;
    logic [7:0]  s_op2;
    logic [11:0] s_ja;
    logic        s_tw;

    instr_fetch_unit dut (
        .clk         (clk),
        .rstN        (rstN),
        .cycle       (cycle),
        .romNibble   (romNibble),
        .opr         (opr),
        .opa         (opa),
        .operand2    (operand2),
        .jumpAddr    (jumpAddr),
        .twoWord     (twoWord),
        .instrValid  (instrValid),
        .secondFetch (secondFetch),
        .finFetch    (finFetch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One full instruction cycle; outputs are sampled on the negedge inside each cycle.
    task automatic instr_cycle(input logic [7:0] word);
        for (int c = 0; c < 8; c++) begin
            cycle     = 3'(c);
            romNibble = (c == 3) ? word[7:4] : (c == 4) ? word[3:0] : 4'hE;
            @(negedge clk);
            valid_bits[c] = instrValid;
            sf_bits[c]    = secondFetch;
            ff_bits[c]    = finFetch;
            if (c == 5) begin
                s_opr = opr;
                s_opa = opa;
                s_op2 = operand2;
                s_ja  = jumpAddr;
                s_tw  = twoWord;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input string tag, input logic [3:0] e_opr, input logic [3:0] e_opa,
                               input logic [7:0] e_op2, input logic e_tw, input logic [7:0] e_valid,
                               input logic [7:0] e_sf, input logic [7:0] e_ff);
        check({tag, ".opr"},   32'(s_opr),      32'(e_opr));
        check({tag, ".opa"},   32'(s_opa),      32'(e_opa));
        check({tag, ".op2"},   32'(s_op2),      32'(e_op2));
        check({tag, ".jaddr"}, 32'(s_ja),       32'({e_opa, e_op2}));
        check({tag, ".tw"},    32'(s_tw),       32'(e_tw));
        check({tag, ".valid"}, 32'(valid_bits), 32'(e_valid));
        check({tag, ".sf"},    32'(sf_bits),    32'(e_sf));
        check({tag, ".ff"},    32'(ff_bits),    32'(e_ff));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".opr"},   32'(opr),         32'h0);
        check({tag, ".opa"},   32'(opa),         32'h0);
        check({tag, ".op2"},   32'(operand2),    32'h0);
        check({tag, ".jaddr"}, 32'(jumpAddr),    32'h0);
        check({tag, ".tw"},    32'(twoWord),     32'h0);
        check({tag, ".valid"}, 32'(instrValid),  32'h0);
        check({tag, ".sf"},    32'(secondFetch), 32'h0);
        check({tag, ".ff"},    32'(finFetch),    32'h0);
    endtask

    initial begin
        rstN      = 1'b0;
        cycle     = 3'd0;
        romNibble = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstN = 1'b1;

        // 1: NOP then LDM 5
        instr_cycle(8'h00);
        expect_word("t1.nop", 4'h0, 4'h0, 8'h00, 1'b0, 8'hE0, 8'h00, 8'h00);
        instr_cycle(8'hD5);
        expect_word("t1.ldm", 4'hD, 4'h5, 8'h00, 1'b0, 8'hE0, 8'h00, 8'h00);

        // 2: JUN 0x4,0x3 / 0x21
        instr_cycle(8'h43);
        expect_word("t2.w1", 4'hD, 4'h5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        instr_cycle(8'h21);
        expect_word("t2.w2", 4'h4, 4'h3, 8'h21, 1'b1, 8'hE0, 8'hFF, 8'h00);

        // 3: FIM 0x2,0x4 / 0xAB, then SRC 0x2,0x5
        instr_cycle(8'h24);
        expect_word("t3.fim1", 4'h4, 4'h3, 8'h21, 1'b1, 8'h00, 8'h00, 8'h00);
        instr_cycle(8'hAB);
        expect_word("t3.fim2", 4'h2, 4'h4, 8'hAB, 1'b1, 8'hE0, 8'hFF, 8'h00);
        instr_cycle(8'h25);
        expect_word("t3.src", 4'h2, 4'h5, 8'h00, 1'b0, 8'hE0, 8'h00, 8'h00);

        // 4: FIN 0x3,0x2 with data 0xAB
        instr_cycle(8'h32);
        expect_word("t4.fin", 4'h2, 4'h5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        instr_cycle(8'hAB);
        expect_word("t4.data", 4'h3, 4'h2, 8'hAB, 1'b1, 8'hE0, 8'h00, 8'hFF);

        // FIN whose data byte looks like JUN: data only, next word is a fresh LDM 1
        instr_cycle(8'h32);
        instr_cycle(8'h40);
        expect_word("finjun.data", 4'h3, 4'h2, 8'h40, 1'b1, 8'hE0, 8'h00, 8'hFF);
        instr_cycle(8'hD1);
        expect_word("finjun.next", 4'hD, 4'h1, 8'h00, 1'b0, 8'hE0, 8'h00, 8'h00);

        // JUN 0x4,0x0 / 0x40: second word not re-decoded
        instr_cycle(8'h40);
        instr_cycle(8'h40);
        expect_word("jun40.w2", 4'h4, 4'h0, 8'h40, 1'b1, 8'hE0, 8'hFF, 8'h00);
        instr_cycle(8'hD2);
        expect_word("jun40.next", 4'hD, 4'h2, 8'h00, 1'b0, 8'hE0, 8'h00, 8'h00);

        // 5: JMS word 1, then reset at cycle 2 of the second-word fetch
        instr_cycle(8'h50);
        expect_word("t5.jms1", 4'hD, 4'h2, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int c = 0; c < 2; c++) begin
            cycle     = 3'(c);
            romNibble = 4'hE;
            @(posedge clk);
            #1;
        end
        cycle = 3'd2;
        @(negedge clk);
        check("t5.sf_before_rst", 32'(secondFetch), 32'h1);
        rstN = 1'b0;
        #1;
        check_all_zero("t5.rst");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        instr_cycle(8'hD7);
        expect_word("t5.ldm7", 4'hD, 4'h7, 8'h00, 1'b0, 8'hE0, 8'h00, 8'h00);

        // 6: back-to-back JCN 0x1,0x4 / 0x00 and ISZ 0x7,0x0 / 0xFF
        instr_cycle(8'h14);
        expect_word("t6.jcn1", 4'hD, 4'h7, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        instr_cycle(8'h00);
        expect_word("t6.jcn2", 4'h1, 4'h4, 8'h00, 1'b1, 8'hE0, 8'hFF, 8'h00);
        instr_cycle(8'h70);
        expect_word("t6.isz1", 4'h1, 4'h4, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00);
        instr_cycle(8'hFF);
        expect_word("t6.isz2", 4'h7, 4'h0, 8'hFF, 1'b1, 8'hE0, 8'hFF, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
